fib_result_bcd: RTL and testbench

Downstream output stage of the Fibonacci engine: accepts the 128-bit binary `result` word produced by the Fibonacci datapath/controller pair. Converts it to packed BCD with a sequential shift-and-add-3 (double-dabble) loop, one bit per cycle. Presents the decimal digits plus a significant-digit count to the display/UART formatter over a valid/ready handshake. Holds one word in flight; upstream is stalled while a conversion or an unconsumed output is pending.

---
 rtl/fib_pkg.sv | 28 ++
 rtl/fib_result_bcd_if.sv | 30 +++
 rtl/fib_result_bcd_add3.sv | 14 +
 rtl/fib_result_bcd.sv | 138 +++++++++++++
 tb/tb_fib_result_bcd.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci engine output path.
// Holds the result width, the BCD digit count that covers it, the
// conversion-stage state encoding and the per-digit correction helper.
package fib_pkg;

  localparam int FIB_W     = 128;
  localparam int FIB_BCD_D = 39;   // 10^39 > 2^128, so no digit overflow

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LEN   = 2'd2,
    ST_DONE  = 2'd3
  } fib_bcd_state_e;

  // Double-dabble correction: a digit >= 5 would become >= 10 after the
  // next left shift, so pre-add 3 to make the shift carry into the next digit.
  function automatic logic [3:0] bcd_add3_f(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/fib_result_bcd_if.sv
// Handshake bundle between the Fibonacci datapath, the BCD converter and
// the display/UART formatter.
//   in_valid/in_ready/in_data          : binary result from upstream
//   out_valid/out_ready/out_bcd/out_ndigits : decimal result to downstream
// slave  : the converter's view.
// master : the environment's view (upstream producer + downstream consumer).
interface fib_result_bcd_if #(
  parameter int W = fib_pkg::FIB_W,
  parameter int D = fib_pkg::FIB_BCD_D
);
  localparam int NDW = $clog2(D + 1);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [4*D-1:0]   out_bcd;
  logic [NDW-1:0]   out_ndigits;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_ndigits
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndigits
  );
endinterface

// File: rtl/fib_result_bcd_add3.sv
// Single BCD digit correction cell used by the double-dabble loop.
//   d_i : current digit (0..9)
//   d_o : digit + 3 when d_i >= 5, otherwise d_i
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  import fib_pkg::*;

  // Purely combinational digit correction.
  always_comb begin
    d_o = bcd_add3_f(d_i);
  end
endmodule

// File: rtl/fib_result_bcd.sv
// Binary-to-BCD output stage of the Fibonacci engine.
// Converts one W-bit unsigned word at a time with a one-bit-per-cycle
// shift-and-add-3 loop, then reports the packed digits and the number of
// significant digits over a valid/ready handshake.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of fib_result_bcd_if
//         in_valid/in_ready/in_data, out_valid/out_ready/out_bcd/out_ndigits
// Latency from accept edge to out_valid is W+1 cycles. in_ready is
// combinational on out_ready while a result is waiting (DONE).
module fib_result_bcd #(
  parameter int W = fib_pkg::FIB_W,
  parameter int D = fib_pkg::FIB_BCD_D
) (
  input  logic                 clk,
  input  logic                 rst,
  fib_result_bcd_if.slave      bus
);
  import fib_pkg::*;

  localparam int NDW = $clog2(D + 1);
  localparam int CW  = $clog2(W + 1);

  fib_bcd_state_e  state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [4*D-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NDW-1:0]  nd_q, nd_d;
  logic            out_valid_q, out_valid_d;

  logic [4*D-1:0]  bcd_adj_s;
  logic [NDW-1:0]  lead_nd_s;
  logic            in_ready_s;
  logic            accept_s;

  // Per-digit correction ahead of each shift.
  for (genvar g = 0; g < D; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj_s[4*g +: 4])
    );
  end

  // Priority scan: highest nonzero digit wins; an all-zero value reports 1.
  always_comb begin
    lead_nd_s = NDW'(1);
    for (int i = 0; i < D; i++) begin
      lead_nd_s = (bcd_q[4*i +: 4] != 4'd0) ? NDW'(i + 1) : lead_nd_s;
    end
  end

  // Upstream handshake: open when idle, or when the held result leaves now.
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) ||
                 ((state_q == ST_DONE) && bus.out_ready);
    accept_s   = in_ready_s && bus.in_valid;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    nd_d    = nd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          bin_d   = bus.in_data;
          bcd_d   = '0;
          cnt_d   = CW'(W);
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // {BCD, binary} shifts as one register; the binary MSB enters digit 0.
        bcd_d = {bcd_adj_s[4*D-2:0], bin_q[W-1]};
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_LEN: begin
        nd_d    = lead_nd_s;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            bin_d   = bus.in_data;
            bcd_d   = '0;
            cnt_d   = CW'(W);
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset discards any partial conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      nd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      nd_q        <= nd_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The BCD register is only observed while valid, where it is frozen.
  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bcd     = bcd_q;
  assign bus.out_ndigits = nd_q;

endmodule

// File: tb/tb_fib_result_bcd.sv
// Directed and randomized checks of fib_result_bcd against a decimal
// reference built from repeated division by ten.
module tb_fib_result_bcd;
  localparam int W = 128;
  localparam int D = 39;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fib_result_bcd_if #(.W(W), .D(D)) bus ();

  fib_result_bcd #(.W(W), .D(D)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: peel decimal digits off with /10 and %10.
  function automatic logic [4*D-1:0] ref_bcd(input logic [W-1:0] v);
    logic [4*D-1:0] r;
    logic [W-1:0]   x;
    logic [W-1:0]   dig;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      dig = x % W'(10);
      r[4*i +: 4] = dig[3:0];
      x = x / W'(10);
    end
    return r;
  endfunction

  function automatic int ref_nd(input logic [W-1:0] v);
    int n;
    logic [W-1:0] x;
    n = 0;
    x = v;
    while (x != '0) begin
      n++;
      x = x / W'(10);
    end
    return (n == 0) ? 1 : n;
  endfunction

  function automatic bit digits_ok(input logic [4*D-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid, reporting cycles since the accept edge (999 on timeout).
  task automatic wait_valid(output int lat);
    lat = 999;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic send_wait(input logic [W-1:0] v, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = v;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] v);
    chk({tag, "_bcd"}, 160'(bus.out_bcd), 160'(ref_bcd(v)));
    chk({tag, "_nd"},  160'(bus.out_ndigits), 160'(ref_nd(v)));
  endtask

  initial begin
    int              lat;
    logic [W-1:0]    v;
    logic [W-1:0]    word;
    logic [W-1:0]    e;
    logic [W-1:0]    expq[$];
    logic            vld;
    int              sent;
    int              got;
    int              cyc;
    localparam int   N = 300;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  160'(bus.in_ready), 160'(1));
    chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
    chk("rst_out_bcd",   160'(bus.out_bcd), 160'(0));
    chk("rst_out_nd",    160'(bus.out_ndigits), 160'(0));
    rst_n = 1'b1;

    // Zero value and exact latency.
    send_wait('0, lat);
    chk("zero_latency", 160'(lat), 160'(129));
    chk("zero_bcd", 160'(bus.out_bcd), 160'(0));
    chk("zero_nd",  160'(bus.out_ndigits), 160'(1));
    release_out();
    chk("zero_valid_drop", 160'(bus.out_valid), 160'(0));

    // F11.
    send_wait(W'(89), lat);
    chk("f11_latency", 160'(lat), 160'(129));
    chk("f11_bcd", 160'(bus.out_bcd), 160'(156'h89));
    chk("f11_nd",  160'(bus.out_ndigits), 160'(2));
    release_out();

    // All ones.
    v = '1;
    send_wait(v, lat);
    chk("max_latency", 160'(lat), 160'(129));
    chk("max_bcd_const", 160'(bus.out_bcd), 160'(156'h340282366920938463463374607431768211455));
    chk("max_nd", 160'(bus.out_ndigits), 160'(39));
    check_result("max_ref", v);
    release_out();

    // Backpressure with a competing word offered while held.
    send_wait(W'(12345), lat);
    chk("bp_latency", 160'(lat), 160'(129));
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 10) begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'(777);
      end
      #1;
      chk("bp_hold_bcd",   160'(bus.out_bcd), 160'(156'h12345));
      chk("bp_hold_nd",    160'(bus.out_ndigits), 160'(5));
      chk("bp_hold_valid", 160'(bus.out_valid), 160'(1));
      chk("bp_in_ready",   160'(bus.in_ready), 160'(0));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_accept_same_cycle", 160'(bus.in_ready), 160'(1));
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_valid_after_hs", 160'(bus.out_valid), 160'(0));
    chk("bp_busy_in_ready",  160'(bus.in_ready), 160'(0));
    wait_valid(lat);
    chk("bp_next_latency", 160'(lat), 160'(129));
    chk("bp_next_bcd", 160'(bus.out_bcd), 160'(156'h777));
    chk("bp_next_nd",  160'(bus.out_ndigits), 160'(3));
    release_out();

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(1) << 100;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  160'(bus.in_ready), 160'(1));
    chk("mid_rst_out_valid", 160'(bus.out_valid), 160'(0));
    chk("mid_rst_out_bcd",   160'(bus.out_bcd), 160'(0));
    chk("mid_rst_out_nd",    160'(bus.out_ndigits), 160'(0));
    chk("mid_rst_state",     160'(dut.state_q), 160'(fib_pkg::ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    send_wait(W'(7), lat);
    chk("post_rst_latency", 160'(lat), 160'(129));
    chk("post_rst_bcd", 160'(bus.out_bcd), 160'(156'h7));
    chk("post_rst_nd",  160'(bus.out_ndigits), 160'(1));
    release_out();

    // Random stream with random valid/ready gaps.
    vld  = 1'b0;
    word = '0;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((got < N) && (cyc < 60000)) begin
      @(negedge clk);
      cyc++;
      if (!vld && (sent < N) && ($urandom_range(0, 3) != 0)) begin
        vld = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          word = W'($urandom_range(0, 100000));
        end else begin
          word = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      bus.in_valid  = vld;
      bus.in_data   = word;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("rand_unexpected_word", 160'(1), 160'(0));
        end else begin
          e = expq.pop_front();
          check_result("rand", e);
          chk("rand_digits_le9", 160'(digits_ok(bus.out_bcd)), 160'(1));
        end
        got++;
      end
      if (vld && bus.in_ready) begin
        expq.push_back(word);
        sent++;
        vld = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rand_delivered", 160'(got), 160'(N));
    chk("rand_sent", 160'(sent), 160'(N));
    chk("rand_queue_empty", 160'(expq.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
